// File: rtl/cache_wb_buffer_pkg.sv
// Shared constants and writeback state encodings for the cache writeback buffer.
// The optional forwarding path is enabled by defining the WB_FORWARD_EN macro.
package cache_wb_buffer_pkg;

  localparam int CACHE_W     = 4;
  localparam int CACHE_LOG_W = 2;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ADDR = 2'd1,
    WB_DATA = 2'd2,
    WB_RESP = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_line_buf.sv
// Storage for one evicted cache line plus its line-aligned address, with two
// independent word read ports (drain beat and read-miss forward).
module wb_line_buf
  import cache_wb_buffer_pkg::*;
#(
  parameter int LINE_WORDS = CACHE_W,
  parameter int OFF_W      = CACHE_LOG_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_load,
  input  logic [31:0]                i_addr,
  input  logic [LINE_WORDS*32-1:0]   i_line,
  input  logic [OFF_W-1:0]           i_beat_sel,
  input  logic [OFF_W-1:0]           i_fwd_sel,
  output logic [31:0]                o_addr,
  output logic [31:0]                o_beat_word,
  output logic [31:0]                o_fwd_word
);

  logic [31:0] r_addr;
  logic [31:0] r_words [LINE_WORDS];
  logic        w_addr_unused;

  // The word-offset and byte bits of the victim address never matter once aligned.
  assign w_addr_unused = ^i_addr[OFF_W+1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_words[i] <= '0;
      end
    end else if (i_load) begin
      r_addr <= {i_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_words[i] <= i_line[i*32 +: 32];
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_beat_word = r_words[i_beat_sel];
  assign o_fwd_word  = r_words[i_fwd_sel];

endmodule

// File: rtl/cache_wb_buffer.sv
// Single-line dirty writeback buffer: captures a victim line in one cycle and
// drains it as address, LINE_WORDS data beats and a response. Define
// WB_FORWARD_EN to let read misses pick up words from the held line.
module cache_wb_buffer
  import cache_wb_buffer_pkg::*;
#(
  parameter int LINE_WORDS = CACHE_W,
  parameter int OFF_W      = CACHE_LOG_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     victim_valid,
  output logic                     victim_ready,
  input  logic [31:0]              victim_addr,
  input  logic [LINE_WORDS*32-1:0] victim_line,
  output logic                     wr_req,
  output logic [31:0]              wr_addr,
  input  logic                     wr_ready,
  output logic                     wr_data_valid,
  output logic [31:0]              wr_data,
  output logic                     wr_data_last,
  input  logic                     wr_data_ready,
  input  logic                     wr_bvalid,
  output logic                     wr_bready,
  output logic                     busy,
  input  logic [31:0]              fwd_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  wb_state_e        r_state;
  wb_state_e        w_next_state;
  logic [OFF_W-1:0] r_beat;
  logic [OFF_W-1:0] w_fwd_sel;
  logic             w_capture;
  logic [31:0]      w_held_addr;
  logic [31:0]      w_beat_word;
  logic [31:0]      w_fwd_word;
  logic             w_fwd_unused;

  assign w_capture = victim_valid & (r_state == WB_IDLE);

  wb_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .OFF_W      (OFF_W)
  ) u_line_buf (
    .clk         (clk),
    .resetn      (resetn),
    .i_load      (w_capture),
    .i_addr      (victim_addr),
    .i_line      (victim_line),
    .i_beat_sel  (r_beat),
    .i_fwd_sel   (w_fwd_sel),
    .o_addr      (w_held_addr),
    .o_beat_word (w_beat_word),
    .o_fwd_word  (w_fwd_word)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Every bus output decodes from state and beat count only, never from inputs.
  always_comb begin
    w_next_state  = r_state;
    victim_ready  = 1'b0;
    wr_req        = 1'b0;
    wr_data_valid = 1'b0;
    wr_data_last  = 1'b0;
    wr_bready     = 1'b0;
    case (r_state)
      WB_IDLE: begin
        victim_ready = 1'b1;
        if (victim_valid) begin
          w_next_state = WB_ADDR;
        end
      end
      WB_ADDR: begin
        wr_req = 1'b1;
        if (wr_ready) begin
          w_next_state = WB_DATA;
        end
      end
      WB_DATA: begin
        wr_data_valid = 1'b1;
        wr_data_last  = (r_beat == LAST_BEAT);
        if (wr_data_ready && (r_beat == LAST_BEAT)) begin
          w_next_state = WB_RESP;
        end
      end
      WB_RESP: begin
        wr_bready = 1'b1;
        if (wr_bvalid) begin
          w_next_state = WB_IDLE;
        end
      end
      default: begin
        w_next_state = WB_IDLE;
      end
    endcase
  end

  // Power-of-two line length lets the counter wrap to zero on the last beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat <= '0;
    end else if (w_capture) begin
      r_beat <= '0;
    end else if ((r_state == WB_DATA) && wr_data_ready) begin
      r_beat <= r_beat + OFF_W'(1);
    end
  end

  assign busy    = (r_state != WB_IDLE);
  assign wr_addr = w_held_addr;
  assign wr_data = w_beat_word;

`ifdef WB_FORWARD_EN
  assign w_fwd_sel    = fwd_addr[OFF_W+1:2];
  assign fwd_hit      = busy & (fwd_addr[31:OFF_W+2] == w_held_addr[31:OFF_W+2]);
  assign fwd_data     = fwd_hit ? w_fwd_word : 32'h0;
  assign w_fwd_unused = ^fwd_addr[1:0];
`else
  assign w_fwd_sel    = '0;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = 32'h0;
  assign w_fwd_unused = ^{fwd_addr, w_fwd_word};
`endif

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Scoreboard bench for cache_wb_buffer: expected beats are queued at capture and
// compared against beats recorded at each data handshake.
module tb_cache_wb_buffer;

  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            victim_valid;
  logic            victim_ready;
  logic [31:0]     victim_addr;
  logic [LW*32-1:0] victim_line;
  logic            wr_req;
  logic [31:0]     wr_addr;
  logic            wr_ready;
  logic            wr_data_valid;
  logic [31:0]     wr_data;
  logic            wr_data_last;
  logic            wr_data_ready;
  logic            wr_bvalid;
  logic            wr_bready;
  logic            busy;
  logic [31:0]     fwd_addr;
  logic            fwd_hit;
  logic [31:0]     fwd_data;

  int vectorCount = 0;
  int missCount   = 0;
  int cycleCount  = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } obs_beat_t;

  exp_beat_t expQ[$];
  obs_beat_t obsQ[$];

  cache_wb_buffer #(
    .LINE_WORDS (LW),
    .OFF_W      (2)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .victim_valid  (victim_valid),
    .victim_ready  (victim_ready),
    .victim_addr   (victim_addr),
    .victim_line   (victim_line),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_ready      (wr_ready),
    .wr_data_valid (wr_data_valid),
    .wr_data       (wr_data),
    .wr_data_last  (wr_data_last),
    .wr_data_ready (wr_data_ready),
    .wr_bvalid     (wr_bvalid),
    .wr_bready     (wr_bready),
    .busy          (busy),
    .fwd_addr      (fwd_addr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data)
  );

  always #5 clk = ~clk;

  // Record every accepted data beat with the cycle it was accepted in.
  always @(posedge clk) begin
    cycleCount++;
    if (resetn && wr_data_valid && wr_data_ready) begin
      obsQ.push_back('{data: wr_data, last: wr_data_last, cyc: cycleCount});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushLine(input logic [LW*32-1:0] line);
    for (int i = 0; i < LW; i++) begin
      expQ.push_back('{data: line[i*32 +: 32], last: (i == LW - 1)});
    end
  endtask

  task automatic makeLine(input logic [31:0] base, output logic [LW*32-1:0] line);
    for (int i = 0; i < LW; i++) begin
      line[i*32 +: 32] = base + 32'(i);
    end
  endtask

  task automatic waitIdle(input string name, input int maxCycles, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < maxCycles) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (busy !== 1'b0) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL %s_timeout: busy=%0b after %0d cycles, expected 0", name, busy, cycles);
    end
  endtask

  task automatic offerLine(input logic [31:0] addr, input logic [LW*32-1:0] line, output int capCycle);
    victim_addr  = addr;
    victim_line  = line;
    victim_valid = 1'b1;
    pushLine(line);
    @(posedge clk); #1;
    capCycle     = cycleCount;
    victim_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn        = 1'b0;
    victim_valid  = 1'b0;
    victim_addr   = 32'h0;
    victim_line   = '0;
    wr_ready      = 1'b1;
    wr_data_ready = 1'b1;
    wr_bvalid     = 1'b1;
    fwd_addr      = 32'h0;
    #1;
    vectorCount++;
    if ({victim_ready, wr_req, wr_data_valid, wr_data_last, wr_bready, busy, fwd_hit} !== 7'b1000000) begin
      missCount++;
      $display("[TB] FAIL reset_ctrl: got %b expected 1000000",
               {victim_ready, wr_req, wr_data_valid, wr_data_last, wr_bready, busy, fwd_hit});
    end
    vectorCount++;
    if ({wr_addr, wr_data, fwd_data} !== 96'h0) begin
      missCount++;
      $display("[TB] FAIL reset_data: got addr=%0h data=%0h fwd=%0h expected 0", wr_addr, wr_data, fwd_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    vectorCount++;
    if (victim_ready !== 1'b1 || busy !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_release: got ready=%0b busy=%0b expected 1/0", victim_ready, busy);
    end
  endtask

  task automatic test_basic_drain;
    logic [LW*32-1:0] line;
    int capCycle, occ, prevCyc;
    exp_beat_t ex;
    obs_beat_t ob;
    line = {32'h44, 32'h33, 32'h22, 32'h11};
    offerLine(32'h1C00_0034, line, capCycle);
    vectorCount++;
    if (wr_req !== 1'b1 || victim_ready !== 1'b0 || busy !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL basic_addr_phase: got req=%0b ready=%0b busy=%0b expected 1/0/1", wr_req, victim_ready, busy);
    end
    vectorCount++;
    if (wr_addr !== 32'h1C00_0030) begin
      missCount++;
      $display("[TB] FAIL basic_wr_addr: got %0h expected 1c000030", wr_addr);
    end
    waitIdle("basic", 30, occ);
    vectorCount++;
    if (occ !== 6) begin
      missCount++;
      $display("[TB] FAIL basic_occupancy: got %0d expected 6", occ);
    end
    prevCyc = capCycle + 1;
    for (int i = 0; i < LW; i++) begin
      vectorCount++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL basic_beat%0d: got no beat expected one", i);
      end else begin
        ob = obsQ.pop_front();
        ex = expQ.pop_front();
        if (ob.data !== ex.data || ob.last !== ex.last || ob.cyc !== prevCyc + 1) begin
          missCount++;
          $display("[TB] FAIL basic_beat%0d: got data=%0h last=%0b cyc=%0d expected data=%0h last=%0b cyc=%0d",
                   i, ob.data, ob.last, ob.cyc, ex.data, ex.last, prevCyc + 1);
        end
        prevCyc = ob.cyc;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [LW*32-1:0] line;
    int capCycle, occ;
    exp_beat_t ex;
    obs_beat_t ob;
    line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    wr_ready = 1'b0;
    offerLine(32'h0000_1008, line, capCycle);
    occ = -1;
    for (int k = 1; k <= 25; k++) begin
      wr_ready      = (k >= 4);
      wr_data_ready = !(k == 7 || k == 8);
      if (k <= 3) begin
        vectorCount++;
        if (wr_req !== 1'b1 || wr_data_valid !== 1'b0 || wr_addr !== 32'h0000_1000) begin
          missCount++;
          $display("[TB] FAIL bp_addr_stall%0d: got req=%0b dv=%0b addr=%0h expected 1/0/1000",
                   k, wr_req, wr_data_valid, wr_addr);
        end
      end
      if (k == 7 || k == 8) begin
        vectorCount++;
        if (wr_data_valid !== 1'b1 || wr_data !== 32'hA2 || wr_addr !== 32'h0000_1000) begin
          missCount++;
          $display("[TB] FAIL bp_data_stall%0d: got dv=%0b data=%0h addr=%0h expected 1/a2/1000",
                   k, wr_data_valid, wr_data, wr_addr);
        end
      end
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        occ = k;
        break;
      end
    end
    wr_ready      = 1'b1;
    wr_data_ready = 1'b1;
    vectorCount++;
    if (occ !== 11) begin
      missCount++;
      $display("[TB] FAIL bp_occupancy: got %0d expected 11", occ);
    end
    for (int i = 0; i < LW; i++) begin
      vectorCount++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL bp_beat%0d: got no beat expected one", i);
      end else begin
        ob = obsQ.pop_front();
        ex = expQ.pop_front();
        if (ob.data !== ex.data || ob.last !== ex.last) begin
          missCount++;
          $display("[TB] FAIL bp_beat%0d: got data=%0h last=%0b expected data=%0h last=%0b",
                   i, ob.data, ob.last, ex.data, ex.last);
        end
      end
    end
    vectorCount++;
    if (obsQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL bp_extra_beats: got %0d extra expected 0", obsQ.size());
    end
  endtask

  task automatic test_resp_wait;
    logic [LW*32-1:0] lineA, lineB;
    int capCycle, occ;
    exp_beat_t ex;
    obs_beat_t ob;
    makeLine(32'h5000_0000, lineA);
    makeLine(32'h6000_0000, lineB);
    wr_bvalid = 1'b0;
    offerLine(32'h2000_0000, lineA, capCycle);
    for (int k = 1; k <= 11; k++) begin
      wr_bvalid    = (k >= 10);
      victim_valid = (k >= 7);
      if (k == 7) begin
        victim_addr = 32'h2000_0104;
        victim_line = lineB;
        pushLine(lineB);
      end
      if (k >= 6 && k <= 10) begin
        vectorCount++;
        if (victim_ready !== 1'b0 || wr_bready !== 1'b1) begin
          missCount++;
          $display("[TB] FAIL resp_wait%0d: got vready=%0b bready=%0b expected 0/1", k, victim_ready, wr_bready);
        end
      end
      @(posedge clk); #1;
      if (k == 10) begin
        vectorCount++;
        if (busy !== 1'b0 || victim_ready !== 1'b1) begin
          missCount++;
          $display("[TB] FAIL resp_to_idle: got busy=%0b vready=%0b expected 0/1", busy, victim_ready);
        end
      end
    end
    victim_valid = 1'b0;
    wr_bvalid    = 1'b1;
    vectorCount++;
    if (busy !== 1'b1 || wr_req !== 1'b1 || wr_addr !== 32'h2000_0100) begin
      missCount++;
      $display("[TB] FAIL resp_new_capture: got busy=%0b req=%0b addr=%0h expected 1/1/20000100", busy, wr_req, wr_addr);
    end
    waitIdle("resp", 30, occ);
    vectorCount++;
    if (occ !== 6) begin
      missCount++;
      $display("[TB] FAIL resp_second_occupancy: got %0d expected 6", occ);
    end
    for (int i = 0; i < 2 * LW; i++) begin
      vectorCount++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL resp_beat%0d: got no beat expected one", i);
      end else begin
        ob = obsQ.pop_front();
        ex = expQ.pop_front();
        if (ob.data !== ex.data || ob.last !== ex.last) begin
          missCount++;
          $display("[TB] FAIL resp_beat%0d: got data=%0h last=%0b expected data=%0h last=%0b",
                   i, ob.data, ob.last, ex.data, ex.last);
        end
      end
    end
  endtask

  task automatic test_early_data_ready;
    logic [LW*32-1:0] line;
    int capCycle, occ;
    exp_beat_t ex;
    obs_beat_t ob;
    makeLine(32'hC0DE_0000, line);
    wr_ready      = 1'b0;
    wr_data_ready = 1'b1;
    offerLine(32'h0000_4020, line, capCycle);
    for (int k = 1; k <= 3; k++) begin
      vectorCount++;
      if (wr_req !== 1'b1 || wr_data_valid !== 1'b0 || wr_data !== 32'hC0DE_0000 || obsQ.size() != 0) begin
        missCount++;
        $display("[TB] FAIL early_addr%0d: got req=%0b dv=%0b data=%0h beats=%0d expected 1/0/c0de0000/0",
                 k, wr_req, wr_data_valid, wr_data, obsQ.size());
      end
      wr_ready = (k == 3);
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    vectorCount++;
    if (wr_data_valid !== 1'b1 || wr_data !== 32'hC0DE_0000) begin
      missCount++;
      $display("[TB] FAIL early_first_beat: got dv=%0b data=%0h expected 1/c0de0000", wr_data_valid, wr_data);
    end
    waitIdle("early", 30, occ);
    for (int i = 0; i < LW; i++) begin
      vectorCount++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL early_beat%0d: got no beat expected one", i);
      end else begin
        ob = obsQ.pop_front();
        ex = expQ.pop_front();
        if (ob.data !== ex.data || ob.last !== ex.last || ob.cyc !== capCycle + 4 + i) begin
          missCount++;
          $display("[TB] FAIL early_beat%0d: got data=%0h last=%0b cyc=%0d expected data=%0h last=%0b cyc=%0d",
                   i, ob.data, ob.last, ob.cyc, ex.data, ex.last, capCycle + 4 + i);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    logic [LW*32-1:0] line;
    int capCycle;
    exp_beat_t ex;
    obs_beat_t ob;
    makeLine(32'h7700_0000, line);
    fwd_addr = 32'h3000_0048;
    offerLine(32'h3000_0040, line, capCycle);
    repeat (3) begin
      @(posedge clk); #1;
    end
    vectorCount++;
    if (wr_data_valid !== 1'b1 || wr_data !== 32'h7700_0002) begin
      missCount++;
      $display("[TB] FAIL areset_pre: got dv=%0b data=%0h expected 1/77000002", wr_data_valid, wr_data);
    end
    #2;
    resetn = 1'b0;
    #1;
    vectorCount++;
    if ({victim_ready, wr_req, wr_data_valid, wr_data_last, wr_bready, busy, fwd_hit} !== 7'b1000000) begin
      missCount++;
      $display("[TB] FAIL areset_ctrl: got %b expected 1000000",
               {victim_ready, wr_req, wr_data_valid, wr_data_last, wr_bready, busy, fwd_hit});
    end
    vectorCount++;
    if ({wr_addr, wr_data, fwd_data} !== 96'h0) begin
      missCount++;
      $display("[TB] FAIL areset_data: got addr=%0h data=%0h fwd=%0h expected 0", wr_addr, wr_data, fwd_data);
    end
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    vectorCount++;
    if (victim_ready !== 1'b1 || busy !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL areset_release: got ready=%0b busy=%0b expected 1/0", victim_ready, busy);
    end
    for (int i = 0; i < 2; i++) begin
      vectorCount++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL areset_beat%0d: got no beat expected one", i);
      end else begin
        ob = obsQ.pop_front();
        ex = expQ.pop_front();
        if (ob.data !== ex.data || ob.last !== ex.last) begin
          missCount++;
          $display("[TB] FAIL areset_beat%0d: got data=%0h last=%0b expected data=%0h last=%0b",
                   i, ob.data, ob.last, ex.data, ex.last);
        end
      end
    end
    vectorCount++;
    if (obsQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL areset_extra_beats: got %0d expected 0", obsQ.size());
    end
    expQ.delete();
    fwd_addr = 32'h0;
  endtask

  task automatic test_forward;
    logic [LW*32-1:0] line;
    logic [31:0] word;
    logic        expHit;
    int capCycle, occ;
    exp_beat_t ex;
    obs_beat_t ob;
    line = {32'h44, 32'h33, 32'h22, 32'h11};
    wr_ready = 1'b0;
    offerLine(32'h1C00_0034, line, capCycle);
    for (int off = 0; off < LW; off++) begin
      fwd_addr = 32'h1C00_0030 + 32'(off * 4);
      #1;
`ifdef WB_FORWARD_EN
      expHit = 1'b1;
      word   = line[off*32 +: 32];
`else
      expHit = 1'b0;
      word   = 32'h0;
`endif
      vectorCount++;
      if (fwd_hit !== expHit || fwd_data !== word) begin
        missCount++;
        $display("[TB] FAIL fwd_word%0d: got hit=%0b data=%0h expected hit=%0b data=%0h", off, fwd_hit, fwd_data, expHit, word);
      end
    end
    fwd_addr = 32'h1C00_0040;
    #1;
    vectorCount++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL fwd_miss_above: got hit=%0b data=%0h expected 0/0", fwd_hit, fwd_data);
    end
    fwd_addr = 32'h1C00_002C;
    #1;
    vectorCount++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL fwd_miss_below: got hit=%0b data=%0h expected 0/0", fwd_hit, fwd_data);
    end
    wr_ready = 1'b1;
    waitIdle("fwd", 30, occ);
    fwd_addr = 32'h1C00_0038;
    #1;
    vectorCount++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL fwd_idle: got hit=%0b data=%0h expected 0/0", fwd_hit, fwd_data);
    end
    for (int i = 0; i < LW; i++) begin
      vectorCount++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        missCount++;
        $display("[TB] FAIL fwd_beat%0d: got no beat expected one", i);
      end else begin
        ob = obsQ.pop_front();
        ex = expQ.pop_front();
        if (ob.data !== ex.data || ob.last !== ex.last) begin
          missCount++;
          $display("[TB] FAIL fwd_beat%0d: got data=%0h last=%0b expected data=%0h last=%0b",
                   i, ob.data, ob.last, ex.data, ex.last);
        end
      end
    end
    fwd_addr = 32'h0;
  endtask

  initial begin
    $display("[TB] cache_wb_buffer bench start");
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_resp_wait();
    test_early_data_ready();
    test_async_reset();
    test_forward();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
